// File: rtl/rgb_fade_pwm.sv
// RGB LED fader: each bit of the CPU register value sets its channel's target brightness.
// Every channel's PWM duty ramps one step per frame toward its target.
module rgb_fade_pwm #(
   parameter int unsigned PRESCALE  = 16,
   parameter int unsigned FADE_STEP = 8,
   parameter int unsigned DUTY_MAX  = 255
) (
   input  logic       int_osc,
   input  logic       rst,
   input  logic [2:0] value,
   input  logic       value_valid,
   output logic       pwm_green,
   output logic       pwm_blue,
   output logic       pwm_red,
   output logic       settled
);

   localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned DW     = 8;
   localparam int unsigned NCH    = 3;
   localparam logic [DW-1:0] DUTY_ON = DW'(DUTY_MAX);
   localparam logic [DW:0]   STEP9   = (DW+1)'(FADE_STEP);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   // Channel index follows the value bit map: 0 red, 1 blue, 2 green
   logic [PS_W-1:0]          r_presc;
   logic [DW-1:0]            r_pwm_cnt;
   logic [NCH-1:0][DW-1:0]   r_tgt;
   logic [NCH-1:0][DW-1:0]   r_duty;
   logic [NCH-1:0]           r_pwm;
   logic                     r_settled;

   logic                     w_tick;
   logic                     w_frame;
   logic [NCH-1:0][DW-1:0]   w_duty_nxt;
   logic [NCH-1:0][DW:0]     w_up;
   logic [NCH-1:0][DW:0]     w_dn_lim;

   assign w_tick  = (r_presc == PS_LAST);
   assign w_frame = w_tick && (r_pwm_cnt == {DW{1'b1}});

   // One saturating step toward target; 9-bit sums avoid wrap and underflow
   always_comb begin
      w_duty_nxt = r_duty;
      w_up       = '0;
      w_dn_lim   = '0;
      for (int i = 0; i < NCH; i++) begin
         w_up[i]     = {1'b0, r_duty[i]} + STEP9;
         w_dn_lim[i] = {1'b0, r_tgt[i]} + STEP9;
         if (r_duty[i] < r_tgt[i]) begin
            w_duty_nxt[i] = (w_up[i] >= {1'b0, r_tgt[i]}) ? r_tgt[i] : w_up[i][DW-1:0];
         end else if (r_duty[i] > r_tgt[i]) begin
            w_duty_nxt[i] = ({1'b0, r_duty[i]} <= w_dn_lim[i]) ? r_tgt[i]
                                                              : r_duty[i] - STEP9[DW-1:0];
         end
      end
   end

   always_ff @(posedge int_osc) begin
      if (rst) begin
         r_presc   <= '0;
         r_pwm_cnt <= '0;
         r_tgt     <= '0;
         r_duty    <= '0;
         r_pwm     <= '0;
         r_settled <= 1'b1;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
         if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + DW'(1);
         end
         // Fade uses the target registered before this edge, so a coincident strobe waits a frame
         if (w_frame) begin
            r_duty <= w_duty_nxt;
         end
         if (value_valid) begin
            for (int i = 0; i < NCH; i++) begin
               r_tgt[i] <= value[i] ? DUTY_ON : '0;
            end
         end
         for (int i = 0; i < NCH; i++) begin
            r_pwm[i] <= (r_pwm_cnt < r_duty[i]);
         end
         r_settled <= (r_duty == r_tgt);
      end
   end

   assign pwm_red   = r_pwm[0];
   assign pwm_blue  = r_pwm[1];
   assign pwm_green = r_pwm[2];
   assign settled   = r_settled;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Directed bench for rgb_fade_pwm: duties are observed as PWM high-counts per 256-tick frame.
module tb_rgb_fade_pwm;

   logic       clk = 1'b0;
   logic       rst;
   logic       rst4;
   logic [2:0] value;
   logic       value_valid;
   logic       pwm_green, pwm_blue, pwm_red, settled;
   logic       pwm_green4, pwm_blue4, pwm_red4, settled4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rgb_fade_pwm #(.PRESCALE(1), .FADE_STEP(64), .DUTY_MAX(255)) u_dut (
      .int_osc(clk), .rst(rst), .value(value), .value_valid(value_valid),
      .pwm_green(pwm_green), .pwm_blue(pwm_blue), .pwm_red(pwm_red), .settled(settled)
   );

   rgb_fade_pwm #(.PRESCALE(4), .FADE_STEP(64), .DUTY_MAX(255)) u_dut4 (
      .int_osc(clk), .rst(rst4), .value(value), .value_valid(value_valid),
      .pwm_green(pwm_green4), .pwm_blue(pwm_blue4), .pwm_red(pwm_red4), .settled(settled4)
   );

   // One full frame of the PRESCALE=1 instance, optionally strobing value at tick 'at'
   task automatic run_frame(input logic sv_en, input logic [2:0] sv, input int at,
                            output int cr, output int cg, output int cb,
                            output logic st0, output logic st_end);
      cr = 0; cg = 0; cb = 0; st0 = 1'b0; st_end = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (sv_en && i == at) begin
            value = sv;
            value_valid = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         value_valid = 1'b0;
         cr = cr + int'(pwm_red);
         cg = cg + int'(pwm_green);
         cb = cb + int'(pwm_blue);
         if (i == 0)   st0    = settled;
         if (i == 255) st_end = settled;
      end
   endtask

   task automatic test_reset();
      int cr, cg, cb;
      logic s0, se;
      rst = 1'b1;
      value = 3'b111;
      value_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({pwm_green, pwm_blue, pwm_red} !== 3'b000) begin
         bad++; $display("FAIL reset_pwm got=%b want=000", {pwm_green, pwm_blue, pwm_red});
      end
      total++;
      if (settled !== 1'b1) begin
         bad++; $display("FAIL reset_settled got=%b want=1", settled);
      end
      for (int f = 0; f < 3; f++) begin
         run_frame(1'b0, 3'b000, 0, cr, cg, cb, s0, se);
         total++;
         if (cr !== 0 || cg !== 0 || cb !== 0 || se !== 1'b1) begin
            bad++; $display("FAIL idle_frame%0d got r=%0d g=%0d b=%0d settled=%b want 0 0 0 1",
                            f, cr, cg, cb, se);
         end
      end
   endtask

   task automatic test_fade_up();
      int cr, cg, cb;
      logic s0, se;
      int exp_r[5] = '{0, 64, 128, 192, 255};
      for (int f = 0; f < 5; f++) begin
         run_frame(f == 0, 3'b001, 0, cr, cg, cb, s0, se);
         total++;
         if (cr !== exp_r[f] || cg !== 0 || cb !== 0) begin
            bad++; $display("FAIL fade_up_frame%0d got r=%0d g=%0d b=%0d want r=%0d g=0 b=0",
                            f, cr, cg, cb, exp_r[f]);
         end
         if (f == 0) begin
            total++;
            if (se !== 1'b0) begin
               bad++; $display("FAIL fade_up_unsettled got=%b want=0", se);
            end
         end else begin
            total++;
            if (s0 !== (f == 4)) begin
               bad++; $display("FAIL fade_up_settled_f%0d got=%b want=%b", f, s0, f == 4);
            end
         end
      end
   endtask

   task automatic test_fade_down();
      int cr, cg, cb;
      logic s0, se;
      int exp_gb[4] = '{64, 128, 192, 255};
      int exp_dn[4] = '{191, 127, 63, 0};
      run_frame(1'b1, 3'b111, 0, cr, cg, cb, s0, se);
      total++;
      if (cr !== 255 || cg !== 0 || cb !== 0) begin
         bad++; $display("FAIL all_on_start got r=%0d g=%0d b=%0d want 255 0 0", cr, cg, cb);
      end
      for (int f = 0; f < 4; f++) begin
         run_frame(1'b0, 3'b000, 0, cr, cg, cb, s0, se);
         total++;
         if (cr !== 255 || cg !== exp_gb[f] || cb !== exp_gb[f]) begin
            bad++; $display("FAIL all_on_ramp%0d got r=%0d g=%0d b=%0d want 255 %0d %0d",
                            f, cr, cg, cb, exp_gb[f], exp_gb[f]);
         end
      end
      total++;
      if (s0 !== 1'b1) begin
         bad++; $display("FAIL all_on_settled got=%b want=1", s0);
      end
      run_frame(1'b1, 3'b000, 0, cr, cg, cb, s0, se);
      total++;
      if (cr !== 255 || cg !== 255 || cb !== 255) begin
         bad++; $display("FAIL down_start got r=%0d g=%0d b=%0d want 255 255 255", cr, cg, cb);
      end
      for (int f = 0; f < 4; f++) begin
         run_frame(1'b0, 3'b000, 0, cr, cg, cb, s0, se);
         total++;
         if (cr !== exp_dn[f] || cg !== exp_dn[f] || cb !== exp_dn[f]) begin
            bad++; $display("FAIL down_frame%0d got r=%0d g=%0d b=%0d want %0d each",
                            f, cr, cg, cb, exp_dn[f]);
         end
      end
      total++;
      if (s0 !== 1'b1) begin
         bad++; $display("FAIL down_settled got=%b want=1", s0);
      end
      run_frame(1'b0, 3'b000, 0, cr, cg, cb, s0, se);
      total++;
      if (cr !== 0 || cg !== 0 || cb !== 0) begin
         bad++; $display("FAIL down_off got r=%0d g=%0d b=%0d want 0 0 0", cr, cg, cb);
      end
   endtask

   task automatic test_reverse();
      int cr, cg, cb;
      logic s0, se;
      run_frame(1'b1, 3'b010, 0, cr, cg, cb, s0, se);
      total++;
      if (cb !== 0) begin
         bad++; $display("FAIL rev_start got b=%0d want 0", cb);
      end
      run_frame(1'b1, 3'b000, 0, cr, cg, cb, s0, se);
      total++;
      if (cb !== 64 || cr !== 0 || cg !== 0 || s0 !== 1'b0) begin
         bad++; $display("FAIL rev_mid got r=%0d g=%0d b=%0d settled=%b want 0 0 64 0",
                         cr, cg, cb, s0);
      end
      run_frame(1'b0, 3'b000, 0, cr, cg, cb, s0, se);
      total++;
      if (cb !== 0 || s0 !== 1'b1 || se !== 1'b1) begin
         bad++; $display("FAIL rev_end got b=%0d settled=%b/%b want 0 1/1", cb, s0, se);
      end
   endtask

   task automatic test_boundary_strobe();
      int cr, cg, cb;
      logic s0, se;
      // Tick 255's edge is the frame boundary
      run_frame(1'b1, 3'b100, 255, cr, cg, cb, s0, se);
      total++;
      if (cg !== 0) begin
         bad++; $display("FAIL bnd_frame0 got g=%0d want 0", cg);
      end
      run_frame(1'b0, 3'b000, 0, cr, cg, cb, s0, se);
      total++;
      if (cg !== 0 || s0 !== 1'b0) begin
         bad++; $display("FAIL bnd_old_target got g=%0d settled=%b want 0 0", cg, s0);
      end
      run_frame(1'b0, 3'b000, 0, cr, cg, cb, s0, se);
      total++;
      if (cg !== 64 || cr !== 0 || cb !== 0) begin
         bad++; $display("FAIL bnd_new_target got r=%0d g=%0d b=%0d want 0 64 0", cr, cg, cb);
      end
   endtask

   task automatic test_prescale_reset();
      int hr, hg, hb, viol, bad_idle;
      logic [2:0] prev;
      rst4 = 1'b0;
      value = 3'b111;
      value_valid = 1'b1;
      hr = 0; hg = 0; hb = 0; viol = 0; prev = 3'b000;
      for (int n = 1; n <= 2048; n++) begin
         @(posedge clk);
         @(negedge clk);
         value_valid = 1'b0;
         if (n == 2) begin
            total++;
            if (settled4 !== 1'b0) begin
               bad++; $display("FAIL ps4_unsettled got=%b want=0", settled4);
            end
         end
         if (n == 1024) begin
            total++;
            if (hr !== 0 || hg !== 0 || hb !== 0) begin
               bad++; $display("FAIL ps4_frame0 got r=%0d g=%0d b=%0d want 0 0 0", hr, hg, hb);
            end
            hr = 0; hg = 0; hb = 0;
         end else begin
            hr = hr + int'(pwm_red4);
            hg = hg + int'(pwm_green4);
            hb = hb + int'(pwm_blue4);
         end
         if ({pwm_green4, pwm_blue4, pwm_red4} !== prev && (n % 4) != 1) viol++;
         prev = {pwm_green4, pwm_blue4, pwm_red4};
      end
      total++;
      if (hr !== 256 || hg !== 256 || hb !== 256) begin
         bad++; $display("FAIL ps4_frame1 got r=%0d g=%0d b=%0d want 256 each", hr, hg, hb);
      end
      total++;
      if (viol !== 0) begin
         bad++; $display("FAIL ps4_transitions got violations=%0d want 0", viol);
      end
      repeat (500) @(posedge clk);
      @(negedge clk);
      rst4 = 1'b1;
      value = 3'b111;
      value_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst4 = 1'b0;
      value_valid = 1'b0;
      total++;
      if ({pwm_green4, pwm_blue4, pwm_red4} !== 3'b000 || settled4 !== 1'b1) begin
         bad++; $display("FAIL ps4_reset got pwm=%b settled=%b want 000 1",
                         {pwm_green4, pwm_blue4, pwm_red4}, settled4);
      end
      bad_idle = 0;
      for (int n = 0; n < 2100; n++) begin
         @(posedge clk);
         @(negedge clk);
         if ({pwm_green4, pwm_blue4, pwm_red4} !== 3'b000 || settled4 !== 1'b1) bad_idle++;
      end
      total++;
      if (bad_idle !== 0) begin
         bad++; $display("FAIL ps4_after_reset got bad_samples=%0d want 0", bad_idle);
      end
   endtask

   initial begin
      rst = 1'b1;
      rst4 = 1'b1;
      value = 3'b000;
      value_valid = 1'b0;
      test_reset();
      test_fade_up();
      test_fade_down();
      test_reverse();
      test_boundary_strobe();
      test_prescale_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
